poly_addsub_stream: RTL and testbench

Streaming coefficient-wise polynomial adder/subtractor mod q=3329 for the Kyber datapath. Accepts one 256-coefficient polynomial pair per job over a valid/ready input, returns (a+b) mod q or (a−b) mod q over a valid/ready output, and marks the final coefficient. Internally it sequences the combinational correctors: cond_sub_q after addition, cond_add_q after subtraction. It sits between polynomial RAM readers and writers.

---
 rtl/poly_addsub_stream_pkg.sv | 17 +
 rtl/poly_addsub_stream_pipe.sv | 105 ++++++++++
 rtl/poly_addsub_stream.sv | 89 ++++++++
 tb/tb_poly_addsub_stream.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_addsub_stream_pkg.sv
// Shared constants and FSM encoding for the Kyber coefficient add/sub stream.
package poly_addsub_stream_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int COEF_W  = 12;
    localparam int RAW_W   = COEF_W + 1;
    localparam int CNT_W   = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/poly_addsub_stream_pipe.sv
// Modular correctors and the two-stage valid/ready add/sub datapath with last-tag propagation.
module cond_sub_q
    import poly_addsub_stream_pkg::*;
(
    input  logic [RAW_W-1:0]  val_i,
    output logic [COEF_W-1:0] res_o
);
    logic [COEF_W-1:0] diff;

    // Modulo-4096 subtraction is exact because the true difference lies in [0, q).
    assign diff  = val_i[COEF_W-1:0] - COEF_W'(KYBER_Q);
    assign res_o = (val_i >= RAW_W'(KYBER_Q)) ? diff : val_i[COEF_W-1:0];
endmodule

module cond_add_q
    import poly_addsub_stream_pkg::*;
(
    input  logic [RAW_W-1:0]  raw_i,
    output logic [COEF_W-1:0] res_o
);
    logic [COEF_W-1:0] sum;

    assign sum   = raw_i[COEF_W-1:0] + COEF_W'(KYBER_Q);
    assign res_o = raw_i[RAW_W-1] ? sum : raw_i[COEF_W-1:0];
endmodule

module poly_addsub_stream_pipe
    import poly_addsub_stream_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              op_i,
    input  logic              in_valid_i,
    input  logic [COEF_W-1:0] a_i,
    input  logic [COEF_W-1:0] b_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [COEF_W-1:0] out_data_o,
    output logic              out_last_o
);
    logic              s1_valid_q, s1_valid_d;
    logic [RAW_W-1:0]  s1_raw_q, s1_raw_d;
    logic              s1_last_q, s1_last_d;
    logic              s2_valid_q, s2_valid_d;
    logic [COEF_W-1:0] s2_data_q, s2_data_d;
    logic              s2_last_q, s2_last_d;
    logic              s1_load, s2_load;
    logic [COEF_W-1:0] sub_fix, add_fix, corrected;

    cond_sub_q u_cond_sub (.val_i(s1_raw_q), .res_o(sub_fix));
    cond_add_q u_cond_add (.raw_i(s1_raw_q), .res_o(add_fix));

    assign corrected = op_i ? add_fix : sub_fix;

    always_comb begin
        s2_load    = !s2_valid_q || out_ready_i;
        s1_load    = !s1_valid_q || s2_load;
        s1_valid_d = s1_valid_q;
        s1_raw_d   = s1_raw_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_last_d  = s2_last_q;
        if (s1_load) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_raw_d  = op_i ? ({1'b0, a_i} - {1'b0, b_i}) : ({1'b0, a_i} + {1'b0, b_i});
                s1_last_d = in_last_i;
            end
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = corrected;
                s2_last_d = s1_last_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_raw_q   <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_raw_q   <= s1_raw_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_last_q  <= s2_last_d;
        end
    end

    assign in_ready_o  = s1_load;
    assign out_valid_o = s2_valid_q;
    assign out_data_o  = s2_data_q;
    // Stale tags linger in an empty stage 2, so last is qualified by valid.
    assign out_last_o  = s2_valid_q && s2_last_q;
endmodule

// File: rtl/poly_addsub_stream.sv
// Job sequencer for streaming (a+b) mod q / (a-b) mod q over one 256-coefficient polynomial pair.
module poly_addsub_stream
    import poly_addsub_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    output logic              busy,
    output logic              done,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [COEF_W-1:0] s_a,
    input  logic [COEF_W-1:0] s_b,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [COEF_W-1:0] m_data,
    output logic              m_last,
    output logic [1:0]        dbg_state
);
    // Handshakes: a transfer happens on a cycle where valid && ready are both high at the
    // rising edge; valid never waits on ready, and s_ready may depend combinationally on m_ready.
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             pipe_in_ready;
    logic             in_fire, in_last;

    assign s_ready = (state_q == ST_RUN) && pipe_in_ready;
    assign in_fire = s_valid && s_ready;
    assign in_last = (cnt_q == CNT_W'(KYBER_N - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_fire) begin
                    cnt_d = cnt_q + 1'b1;
                    if (in_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (m_valid && m_ready && m_last) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    poly_addsub_stream_pipe u_pipe (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .op_i        (op_q),
        .in_valid_i  (in_fire),
        .a_i         (s_a),
        .b_i         (s_b),
        .in_last_i   (in_last),
        .in_ready_o  (pipe_in_ready),
        .out_valid_o (m_valid),
        .out_ready_i (m_ready),
        .out_data_o  (m_data),
        .out_last_o  (m_last)
    );

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;
endmodule

// File: tb/tb_poly_addsub_stream.sv
// Directed bench for poly_addsub_stream: arithmetic model, per-cycle scoreboard, literal pins.
module tb_poly_addsub_stream;
    import poly_addsub_stream_pkg::*;

    localparam int Q = 3329;
    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        s_valid = 1'b0;
    logic [11:0] s_a = '0;
    logic [11:0] s_b = '0;
    logic        m_ready = 1'b1;
    logic        busy, done, s_ready, m_valid, m_last;
    logic [11:0] m_data;
    logic [1:0]  dbg_state;

    poly_addsub_stream dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .busy(busy), .done(done),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [11:0] model(input bit sub, input int a, input int b);
        int r;
        r = sub ? (a - b) : (a + b);
        r = ((r % Q) + Q) % Q;
        return 12'(r);
    endfunction

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    bit          exp_last_q[$];
    logic [11:0] out_log[$];
    bit          job_op = 1'b0;
    int          in_cnt = 0;
    int unsigned first_in_cyc = 0, first_out_cyc = 0, last_out_cyc = 0;
    bit          prev_last_fire = 1'b0, prev_stall = 1'b0, prev_mlast = 1'b0;
    logic [11:0] prev_data = '0;
    logic [11:0] e;
    bit          el;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_last_fire = 1'b0;
            prev_stall     = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {19'd0, m_valid, m_last, m_data}, {19'd0, 1'b1, prev_mlast, prev_data});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got %0d expected no output", m_data);
                end else begin
                    e  = exp_q.pop_front();
                    el = exp_last_q.pop_front();
                    check("m_data", m_data, e);
                    check("m_last", m_last, el);
                end
                if (out_log.size() == 0) first_out_cyc = cyc;
                out_log.push_back(m_data);
                last_out_cyc = cyc;
            end
            check("done_pulse", done, prev_last_fire);
            prev_last_fire = m_valid && m_ready && m_last;
            prev_stall     = m_valid && !m_ready;
            prev_data      = m_data;
            prev_mlast     = m_last;
            if (s_valid && s_ready) begin
                if (in_cnt == 0) first_in_cyc = cyc;
                exp_q.push_back(model(job_op, s_a, s_b));
                exp_last_q.push_back(in_cnt == N - 1);
                in_cnt = (in_cnt == N - 1) ? 0 : in_cnt + 1;
            end
        end
    end

    // ---------------- drivers ----------------
    int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(1));
        endcase
    end

    task automatic do_start(input bit o);
        job_op = o;
        in_cnt = 0;
        out_log.delete();
        start = 1'b1;
        op = o;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic send_pair(input int a, input int b, input int gap_pct);
        bit got;
        int guard;
        while (int'($urandom_range(99)) < gap_pct) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_a = 12'(a);
        s_b = 12'(b);
        s_valid = 1'b1;
        got = 1'b0;
        guard = 0;
        while (!got && guard < 1000) begin
            @(negedge clk);
            got = s_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        s_valid = 1'b0;
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got no s_ready expected handshake");
        end
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (done !== 1'b1 && guard < 5000);
        check("done_reached", done, 1);
        @(posedge clk);
        #1;
        check("idle_after_done", {30'd0, dbg_state}, ST_IDLE);
        check("busy_after_done", busy, 0);
    endtask

    task automatic job_end_checks();
        check("out_count", out_log.size(), N);
        check("exp_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        check("rst_state", {30'd0, dbg_state}, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Add job, no backpressure
        ready_mode = 1;
        do_start(1'b0);
        send_pair(3328, 1, 0);
        send_pair(1664, 1665, 0);
        send_pair(0, 0, 0);
        for (int i = 0; i < 253; i++) send_pair(5, 7, 0);
        wait_done();
        job_end_checks();
        check("add_r0", out_log[0], 0);
        check("add_r1", out_log[1], 0);
        check("add_r2", out_log[2], 0);
        check("add_r3", out_log[3], 12);
        check("add_r255", out_log[255], 12);
        check("add_latency", first_out_cyc - first_in_cyc, 2);
        check("add_job_span", last_out_cyc - first_in_cyc, N + 1);

        // Sub job started the cycle after done
        do_start(1'b1);
        send_pair(0, 1, 0);
        send_pair(1, 3328, 0);
        send_pair(3328, 0, 0);
        send_pair(7, 7, 0);
        for (int i = 0; i < 252; i++) send_pair(100, 200, 0);
        wait_done();
        job_end_checks();
        check("sub_r0", out_log[0], 3328);
        check("sub_r1", out_log[1], 2);
        check("sub_r2", out_log[2], 3328);
        check("sub_r3", out_log[3], 0);
        check("sub_r4", out_log[4], 3229);
        check("b2b_latency", first_out_cyc - first_in_cyc, 2);

        // Random valid and ready
        ready_mode = 2;
        do_start(1'b1);
        for (int i = 0; i < N; i++)
            send_pair(int'($urandom_range(3328)), int'($urandom_range(3328)), 50);
        wait_done();
        job_end_checks();
        ready_mode = 1;
        repeat (3) @(posedge clk);
        #1;

        // start and op activity during RUN and DRAIN must be ignored
        do_start(1'b0);
        for (int i = 0; i < N; i++) begin
            op = i[0];
            if (i == 50) start = 1'b1;
            if (i == 52) start = 1'b0;
            send_pair((i * 13) % Q, 3328 - i, 0);
        end
        ready_mode = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        op = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("drain_busy", busy, 1);
            check("drain_state", {30'd0, dbg_state}, ST_DRAIN);
        end
        start = 1'b0;
        ready_mode = 1;
        wait_done();
        job_end_checks();
        check("ign_r1", out_log[1], 3340 % Q);
        repeat (10) @(posedge clk);
        #1;
        check("no_second_job_state", {30'd0, dbg_state}, ST_IDLE);
        check("no_second_job_busy", busy, 0);

        // Reset in the middle of a job
        do_start(1'b0);
        for (int i = 0; i < 100; i++) send_pair(i, 2 * i, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        exp_last_q.delete();
        in_cnt = 0;
        out_log.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_start(1'b0);
        for (int i = 0; i < N; i++) send_pair((i * 7) % Q, (i * 11) % Q, 0);
        wait_done();
        job_end_checks();
        check("post_rst_r255", out_log[255], (255 * 18) % Q);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
